// File: rtl/add_seq_pkg.sv
// Shared types and sizing helpers for the chunked carry-propagate adder.
package add_seq_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic int nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  // Width of the final, possibly partial, chunk.
  function automatic int last_chunk_bits(input int width, input int chunk);
    return width - (nchunk(width, chunk) - 1) * chunk;
  endfunction

endpackage

// File: rtl/FullAdder.sv
// One-bit full adder cell.
module FullAdder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple adder built from a chain of FullAdder cells.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    FullAdder u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[CHUNK];

endmodule

// File: rtl/add_seq_chunked.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per cycle with a registered carry,
// valid/ready handshakes on operand and result sides.
module add_seq_chunked
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 50,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NCHUNK    = nchunk(WIDTH, CHUNK);
  localparam int LAST_BITS = last_chunk_bits(WIDTH, CHUNK);
  localparam int CW        = $clog2(NCHUNK + 1);

  localparam logic [WIDTH:0]   ONE_SH = (WIDTH+1)'(1) << CHUNK;
  localparam logic [WIDTH-1:0] CMASK  = WIDTH'(ONE_SH - 1'b1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, sum_r, sum_nxt;
  logic             carry, cout_r, cout_bit;
  logic [CW-1:0]    cnt;
  logic             accept, step, last;
  logic [CHUNK-1:0] x, y, s;
  logic             co;
  int               off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign last = (cnt == CW'(NCHUNK - 1));

  // Shifting past WIDTH zero-fills, which masks the unused top of the last chunk.
  always_comb begin
    off     = int'(cnt) * CHUNK;
    x       = CHUNK'(a_r >> off);
    y       = CHUNK'(b_r >> off);
    sum_nxt = (sum_r & ~(CMASK << off)) | (WIDTH'(s) << off);
  end

  chunk_adder #(.CHUNK(CHUNK)) u_add (
    .x  (x),
    .y  (y),
    .ci (carry),
    .s  (s),
    .co (co)
  );

  // With a partial last chunk, the carry out of bit WIDTH-1 lands in the first padded sum bit.
  if (LAST_BITS == CHUNK) begin : g_cout_full
    assign cout_bit = co;
  end else begin : g_cout_part
    assign cout_bit = s[LAST_BITS];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
    end else begin
      if (accept) begin
        a_r   <= a;
        b_r   <= sub ? ~b : b;
        carry <= sub;
        cnt   <= '0;
      end
      if (step) begin
        sum_r <= sum_nxt;
        carry <= co;
        cnt   <= cnt + CW'(1);
        if (last) cout_r <= cout_bit;
      end
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_add_seq_chunked.sv
// Directed and random checks of add_seq_chunked at CHUNK = 8, 1 and 50.
module tb_add_seq_chunked;

  localparam int WIDTH = 50;
  localparam int NCH8  = 7;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid, sub, out_ready;
  logic [WIDTH-1:0]      a, b;
  logic [2:0]            in_ready, out_valid, cout;
  logic [2:0][WIDTH-1:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_seq_chunked #(.WIDTH(WIDTH), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid[0]), .out_ready(out_ready), .sum(sum[0]), .cout(cout[0]));

  add_seq_chunked #(.WIDTH(WIDTH), .CHUNK(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid[1]), .out_ready(out_ready), .sum(sum[1]), .cout(cout[1]));

  add_seq_chunked #(.WIDTH(WIDTH), .CHUNK(50)) dut50 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid[2]), .out_ready(out_ready), .sum(sum[2]), .cout(cout[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single transaction on the CHUNK=8 instance with out_ready held high.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic isub, input logic [WIDTH-1:0] esum, input logic ecout);
    int lat;
    @(negedge clk);
    a = ia; b = ib; sub = isub; in_valid = 1'b1; out_ready = 1'b1;
    chk({tag, "_in_ready"}, 64'(in_ready[0]), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(NCH8));
    chk({tag, "_sum"}, 64'(sum[0]), 64'(esum));
    chk({tag, "_cout"}, 64'(cout[0]), 64'(ecout));
    @(posedge clk); #1;
    chk({tag, "_ov_drop"}, 64'(out_valid[0]), 64'd0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int               cyc, seen;
    logic [2:0]       done;
    logic [WIDTH-1:0] ra, rb, hold_sum;
    logic             rsub, hold_cout;
    logic [WIDTH:0]   exp51;

    rst = 1'b1; in_valid = 1'b0; sub = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("rst_sum", 64'(sum[0]), 64'd0);
    chk("rst_cout", 64'(cout[0]), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd7);

    run_op("add_basic", 50'd1, 50'd2, 1'b0, 50'd3, 1'b0);
    run_op("ripple", 50'h3_FFFF_FFFF_FFFF, 50'd1, 1'b0, 50'd0, 1'b1);
    run_op("sub_neg", 50'd5, 50'd7, 1'b1, 50'h3_FFFF_FFFF_FFFE, 1'b0);
    run_op("sub_pos", 50'd7, 50'd5, 1'b1, 50'd2, 1'b1);
    run_op("sub_b0", 50'h1_2345_6789_ABCD, 50'd0, 1'b1, 50'h1_2345_6789_ABCD, 1'b1);
    run_op("add_mid", 50'h0_00FF_0000_00FF, 50'h0_0001_0000_0001, 1'b0, 50'h0_0100_0000_0100, 1'b0);

    // Backpressure in DONE with extra requests offered meanwhile.
    @(negedge clk);
    a = 50'd100; b = 50'd23; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid[0] && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_reach_done", 64'(out_valid[0]), 64'd1);
    hold_sum = sum[0]; hold_cout = cout[0];
    chk("bp_sum", 64'(hold_sum), 64'd123);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 50'd999; b = 50'd1;
      chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
      chk("bp_out_valid", 64'(out_valid[0]), 64'd1);
      chk("bp_sum_stable", 64'(sum[0]), 64'(hold_sum));
      chk("bp_cout_stable", 64'(cout[0]), 64'(hold_cout));
    end
    @(negedge clk);
    chk("bp_final_sum", 64'(sum[0]), 64'd123);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 64'(out_valid[0]), 64'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    chk("bp_no_extra", 64'(seen), 64'd0);

    // Reset during BUSY cycle 3.
    @(negedge clk);
    a = 50'd3; b = 50'd4; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("mid_rst_sum", 64'(sum[0]), 64'd0);
    chk("mid_rst_cout", 64'(cout[0]), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_release", 64'(in_ready), 64'd7);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid != 3'b000) seen++;
    end
    chk("mid_rst_no_stale", 64'(seen), 64'd0);

    // Random transactions run in lockstep on all three chunk widths.
    for (int t = 0; t < 1000; t++) begin
      ra    = WIDTH'({$urandom(), $urandom()});
      rb    = WIDTH'({$urandom(), $urandom()});
      rsub  = 1'($urandom_range(0, 1));
      exp51 = {1'b0, ra} + {1'b0, (rsub ? ~rb : rb)} + (WIDTH+1)'(rsub);
      @(negedge clk);
      a = ra; b = rb; sub = rsub; in_valid = 1'b1;
      chk("rnd_in_ready", 64'(in_ready), 64'd7);
      @(posedge clk); #1;
      in_valid = 1'b0;
      done = 3'b000;
      cyc  = 0;
      while (done != 3'b111 && cyc < 300) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
        for (int k = 0; k < 3; k++) begin
          if (!done[k] && out_valid[k] && out_ready) begin
            chk($sformatf("rnd_result_dut%0d_t%0d", k, t), 64'({cout[k], sum[k]}), 64'(exp51));
            done[k] = 1'b1;
          end
        end
        cyc++;
      end
      if (done != 3'b111) chk("rnd_timeout", 64'(done), 64'd7);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
